// File: rtl/inst_fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buffer_pkg
// Brief    : Shared widths, entry type and reset PC for the fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_buffer_pkg;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int ENTRY_W = PC_W + INST_W;

    localparam logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fb_entry_t;

endpackage : inst_fetch_buffer_pkg
`default_nettype wire

// File: rtl/inst_fetch_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buffer_mem
// Brief    : DEPTH-entry register array, two write ports, two async reads.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buffer_mem
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             i_we1,
    input  logic [PTR_W-1:0] i_waddr1,
    input  fb_entry_t        i_wdata1,
    input  logic             i_we2,
    input  logic [PTR_W-1:0] i_waddr2,
    input  fb_entry_t        i_wdata2,
    input  logic [PTR_W-1:0] i_raddr1,
    input  logic [PTR_W-1:0] i_raddr2,
    output fb_entry_t        o_rdata1,
    output fb_entry_t        o_rdata2
);

    fb_entry_t r_mem [DEPTH];

    // Slot-2 write is issued last so it wins if both target one address.
    always_ff @(posedge clk) begin
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
        if (i_we2) begin
            r_mem[i_waddr2] <= i_wdata2;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule : inst_fetch_buffer_mem
`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buffer
// Brief    : Dual-issue in-order instruction queue between fetch and decode.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_en1,
    input  logic              push_en2,
    input  logic [PC_W-1:0]   push_pc1,
    input  logic [INST_W-1:0] push_inst1,
    input  logic [PC_W-1:0]   push_pc2,
    input  logic [INST_W-1:0] push_inst2,
    input  logic              pop1,
    input  logic              pop2,
    output logic              out_valid1,
    output logic              out_valid2,
    output logic [PC_W-1:0]   out_pc1,
    output logic [INST_W-1:0] out_inst1,
    output logic [PC_W-1:0]   out_pc2,
    output logic [INST_W-1:0] out_inst2,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] c_full_level = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W-1:0] r_head_ptr;
    logic [PTR_W-1:0] r_tail_ptr;
    logic [PTR_W:0]   r_count;

    logic [1:0]       w_npush_req;
    logic [1:0]       w_npush;
    logic [1:0]       w_npop_req;
    logic [1:0]       w_npop;
    logic             w_we1;
    logic             w_we2;
    logic [PTR_W-1:0] w_head_nxt1;
    logic [PTR_W-1:0] w_tail_nxt1;
    fb_entry_t        w_wdata1;
    fb_entry_t        w_wdata2;
    fb_entry_t        w_rdata1;
    fb_entry_t        w_rdata2;

    assign full  = (r_count > c_full_level);
    assign empty = (r_count == '0);
    assign count = r_count;

    // Pushes are dropped wholesale while full; pops are clamped to occupancy.
    assign w_npush_req = {1'b0, push_en1} + {1'b0, push_en1 & push_en2};
    assign w_npush     = full ? 2'd0 : w_npush_req;
    assign w_npop_req  = {1'b0, pop1} + {1'b0, pop1 & pop2};
    assign w_npop      = ((PTR_W+1)'(w_npop_req) > r_count) ? r_count[1:0] : w_npop_req;

    assign w_head_nxt1 = r_head_ptr + PTR_W'(1);
    assign w_tail_nxt1 = r_tail_ptr + PTR_W'(1);

    assign w_we1 = ~flush & (w_npush != 2'd0);
    assign w_we2 = ~flush & (w_npush == 2'd2);

    assign w_wdata1 = '{pc: push_pc1, inst: push_inst1};
    assign w_wdata2 = '{pc: push_pc2, inst: push_inst2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else if (flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
        end else begin
            r_tail_ptr <= r_tail_ptr + PTR_W'(w_npush);
            r_head_ptr <= r_head_ptr + PTR_W'(w_npop);
            r_count    <= r_count + (PTR_W+1)'(w_npush) - (PTR_W+1)'(w_npop);
        end
    end

    inst_fetch_buffer_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk      (clk),
        .i_we1    (w_we1),
        .i_waddr1 (r_tail_ptr),
        .i_wdata1 (w_wdata1),
        .i_we2    (w_we2),
        .i_waddr2 (w_tail_nxt1),
        .i_wdata2 (w_wdata2),
        .i_raddr1 (r_head_ptr),
        .i_raddr2 (w_head_nxt1),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    assign out_valid1 = (r_count >= (PTR_W+1)'(1));
    assign out_valid2 = (r_count >= (PTR_W+1)'(2));

    // Array contents are undefined after reset, so invalid slots read as zero.
    assign out_pc1   = out_valid1 ? w_rdata1.pc   : '0;
    assign out_inst1 = out_valid1 ? w_rdata1.inst : '0;
    assign out_pc2   = out_valid2 ? w_rdata2.pc   : '0;
    assign out_inst2 = out_valid2 ? w_rdata2.inst : '0;

endmodule : inst_fetch_buffer
`default_nettype wire

// File: tb/tb_inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_buffer
// Brief    : Directed self-checking bench for inst_fetch_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_buffer;
    import inst_fetch_buffer_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_en1, push_en2;
    logic [31:0] push_pc1, push_inst1, push_pc2, push_inst2;
    logic        pop1, pop2;
    logic        out_valid1, out_valid2;
    logic [31:0] out_pc1, out_inst1, out_pc2, out_inst2;
    logic        full, empty;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_viol  = 0;

    inst_fetch_buffer #(.DEPTH(16), .PTR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_en1   (push_en1),
        .push_en2   (push_en2),
        .push_pc1   (push_pc1),
        .push_inst1 (push_inst1),
        .push_pc2   (push_pc2),
        .push_inst2 (push_inst2),
        .pop1       (pop1),
        .pop2       (pop2),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_pc1    (out_pc1),
        .out_inst1  (out_inst1),
        .out_pc2    (out_pc2),
        .out_inst2  (out_inst2),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch must never push while full; count every occurrence.
    always @(posedge clk) begin
        if (!rst && full && push_en1) n_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; push_en1 = 0; push_en2 = 0; pop1 = 0; pop2 = 0;
        push_pc1 = 0; push_inst1 = 0; push_pc2 = 0; push_inst2 = 0;
    endtask

    task automatic push(input logic two, input logic [31:0] pc);
        push_en1 = 1; push_en2 = two;
        push_pc1 = pc;      push_inst1 = {8'h24, pc[23:0]};
        push_pc2 = pc + 4;  push_inst2 = {8'h24, pc[23:0] + 24'd4};
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        chk("rst_valid1", out_valid1, 0);
        chk("rst_valid2", out_valid2, 0);
        chk("rst_empty",  empty, 1);
        chk("rst_full",   full, 0);
        chk("rst_count",  count, 0);
        chk("rst_pc1",    out_pc1, 0);
        chk("rst_inst1",  out_inst1, 0);
        chk("rst_pc2",    out_pc2, 0);
        chk("rst_inst2",  out_inst2, 0);

        // Dual push into empty buffer
        push_en1 = 1; push_en2 = 1;
        push_pc1 = RESET_PC;          push_inst1 = 32'h2408_0001;
        push_pc2 = RESET_PC + 32'd4;  push_inst2 = 32'h2409_0002;
        #1 chk("nobypass_valid1", out_valid1, 0);
        tick(); idle();
        chk("dp_valid1", out_valid1, 1);
        chk("dp_valid2", out_valid2, 1);
        chk("dp_pc1",    out_pc1, 32'hBFC0_0000);
        chk("dp_inst1",  out_inst1, 32'h2408_0001);
        chk("dp_pc2",    out_pc2, 32'hBFC0_0004);
        chk("dp_inst2",  out_inst2, 32'h2409_0002);
        chk("dp_count",  count, 2);

        // Dual pop together with dual push
        pop1 = 1; pop2 = 1; push_en1 = 1; push_en2 = 1;
        push_pc1 = 32'hBFC0_0008; push_inst1 = 32'h240A_0003;
        push_pc2 = 32'hBFC0_000C; push_inst2 = 32'h240B_0004;
        tick(); idle();
        chk("pp_count", count, 2);
        chk("pp_pc1",   out_pc1, 32'hBFC0_0008);
        chk("pp_inst1", out_inst1, 32'h240A_0003);
        chk("pp_pc2",   out_pc2, 32'hBFC0_000C);
        chk("pp_inst2", out_inst2, 32'h240B_0004);

        pop1 = 1; pop2 = 1;
        tick(); idle();
        chk("drain_count", count, 0);
        chk("drain_empty", empty, 1);

        // Single-issue drift: push 2, pop 1 per cycle
        for (int k = 0; k < 7; k++) begin
            push(1, 32'h2000 + 32'(8 * k));
            pop1 = 1;
            tick();
            chk("drift_count", count, 32'(k + 2));
            chk("drift_pc1",   out_pc1, 32'h2000 + 32'(4 * k));
            chk("drift_pc2",   out_pc2, 32'h2004 + 32'(4 * k));
        end
        idle();

        // Fill to full boundary
        for (int k = 0; k < 3; k++) begin
            push(1, 32'h2038 + 32'(8 * k));
            tick();
            chk("fill_count", count, 32'(10 + 2 * k));
        end
        push(0, 32'h2068);
        tick(); idle();
        chk("f15_count", count, 15);
        chk("f15_full",  full, 1);
        chk("f15_pc1",   out_pc1, 32'h2018);

        push(1, 32'hDEAD_0000);
        tick(); idle();
        chk("drop_count", count, 15);
        chk("drop_viol",  n_viol, 1);
        chk("drop_pc1",   out_pc1, 32'h2018);

        pop1 = 1;
        tick(); idle();
        chk("pop1_count", count, 14);
        chk("pop1_full",  full, 0);
        chk("pop1_pc1",   out_pc1, 32'h201C);

        push(1, 32'h206C);
        tick(); idle();
        chk("f16_count", count, 16);
        chk("f16_full",  full, 1);

        for (int k = 0; k < 5; k++) begin
            pop1 = 1; pop2 = 1;
            tick();
        end
        idle();
        chk("pre_fl_count", count, 6);
        chk("pre_fl_pc1",   out_pc1, 32'h2044);
        chk("pre_fl_pc2",   out_pc2, 32'h2048);

        // Flush beats same-cycle push and pop
        push(1, 32'h3000);
        pop1 = 1; pop2 = 1; flush = 1;
        tick(); idle();
        chk("fl_count",  count, 0);
        chk("fl_empty",  empty, 1);
        chk("fl_valid1", out_valid1, 0);
        chk("fl_pc1",    out_pc1, 0);

        push(0, 32'h8000_1000);
        #1 chk("fl_nobypass", out_valid1, 0);
        tick(); idle();
        chk("afl_pc1",    out_pc1, 32'h8000_1000);
        chk("afl_count",  count, 1);
        chk("afl_valid2", out_valid2, 0);

        // Walk both pointers to 15 for the wrap case
        flush = 1;
        tick(); idle();
        for (int i = 0; i < 15; i++) begin
            push(0, 32'h4000 + 32'(4 * i));
            pop1 = 1;
            tick();
        end
        idle();
        pop1 = 1;
        tick(); idle();
        chk("wr_head", dut.r_head_ptr, 15);
        chk("wr_tail", dut.r_tail_ptr, 15);
        chk("wr_count", count, 0);

        push(1, 32'h1000);
        tick(); idle();
        chk("wr_pc1",  out_pc1, 32'h1000);
        chk("wr_pc2",  out_pc2, 32'h1004);
        chk("wr_tail1", dut.r_tail_ptr, 1);

        pop1 = 1; pop2 = 1;
        tick(); idle();
        chk("wr_head1",  dut.r_head_ptr, 1);
        chk("wr_cnt0",   count, 0);
        chk("wr_empty",  empty, 1);

        // Asynchronous reset mid-cycle with 5 entries held
        push(1, 32'h5000); tick();
        push(1, 32'h5008); tick();
        push(0, 32'h5010); tick();
        idle();
        chk("ar_pre_count", count, 5);
        #2 rst = 1;
        #1;
        chk("ar_count",  count, 0);
        chk("ar_valid1", out_valid1, 0);
        chk("ar_pc1",    out_pc1, 0);
        chk("ar_empty",  empty, 1);
        #1 rst = 0;
        tick();
        chk("ar_post_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_buffer
`default_nettype wire
